// File: rtl/load_store_unit_pkg.sv
// Shared opcode, funct3 and state encodings for the load/store unit.
// Also holds the funct3 legality rule so the FSM reads as plain control flow.
package load_store_unit_pkg;

    localparam logic [6:0] OPCODE_L_TYPE = 7'b0000011;
    localparam logic [6:0] OPCODE_S_TYPE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte/half replication and strobes,
// load lane extraction with sign/zero extension, and alignment check.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_low,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [15:0] lane;

    always_comb begin
        lane       = 16'(mem_rdata >> {addr_low, 3'b000});
        wstrb      = 4'b0000;
        wdata      = store_data;
        load_value = 32'd0;
        misaligned = 1'b0;

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_low;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << addr_low;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_low[0];
            end
            2'b10: begin
                wstrb      = 4'b1111;
                misaligned = |addr_low;
            end
            default: misaligned = 1'b1;
        endcase

        case (funct3)
            F3_LB:   load_value = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_value = {{16{lane[15]}}, lane};
            F3_LW:   load_value = mem_rdata;
            F3_LBU:  load_value = {24'd0, lane[7:0]};
            F3_LHU:  load_value = {16'd0, lane};
            default: load_value = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one data-memory access per accepted load/store: request handshake,
// response wait, and a registered, extended load result with done/fault pulses.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] dmem_out,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_offset;
    logic        cap_load;

    logic        is_load;
    logic        is_store;
    logic        accept;
    logic        legal;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_offset;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] load_value;
    logic        misaligned;

    assign is_load  = (opcode == OPCODE_L_TYPE);
    assign is_store = (opcode == OPCODE_S_TYPE);
    assign accept   = (state == LSU_IDLE) && start && (is_load || is_store);

    // One aligner serves both ends: live inputs while idle, captured fields afterwards
    assign sel_funct3 = (state == LSU_IDLE) ? funct3    : cap_funct3;
    assign sel_offset = (state == LSU_IDLE) ? addr[1:0] : cap_offset;

    assign legal = funct3_legal(is_store, funct3) && !misaligned;
    assign busy  = accept || (state == LSU_REQ) || (state == LSU_WAIT);

    lsu_align u_align (
        .funct3     (sel_funct3),
        .addr_low   (sel_offset),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .load_value (load_value),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            done          <= 1'b0;
            fault         <= 1'b0;
            dmem_out      <= 32'd0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wstrb     <= 4'b0000;
            mem_wdata     <= 32'd0;
            cap_funct3    <= 3'd0;
            cap_offset    <= 2'd0;
            cap_load      <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        cap_funct3 <= funct3;
                        cap_offset <= addr[1:0];
                        cap_load   <= is_load;
                        if (legal) begin
                            state         <= LSU_REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= is_store;
                            mem_addr      <= {addr[31:2], 2'b00};
                            mem_wstrb     <= is_store ? wstrb : 4'b0000;
                            mem_wdata     <= is_store ? wdata : 32'd0;
                        end else begin
                            state    <= LSU_DONE;
                            done     <= 1'b1;
                            fault    <= 1'b1;
                            dmem_out <= 32'd0;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_req_ready) begin
                        state         <= LSU_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (mem_rsp_valid) begin
                        state    <= LSU_DONE;
                        done     <= 1'b1;
                        dmem_out <= cap_load ? load_value : 32'd0;
                    end
                end
                LSU_DONE: begin
                    state <= LSU_IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver pushes expected requests and
// completions, a memory responder and a completion monitor pop and compare.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] dmem_out;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          rdy_delay;
        int          rsp_delay;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic        fault;
        logic [31:0] value;
        int          due;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    bit          auto_mem = 1'b1;
    logic [31:0] model_dmem = 32'd0;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .opcode        (opcode),
        .funct3        (funct3),
        .addr          (addr),
        .store_data    (store_data),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .dmem_out      (dmem_out),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: derives the access from byte-lane arithmetic
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         output bit legal, output req_t rq, output logic [31:0] val);
        int     size;
        int     off;
        bit     is_load;
        bit     is_store;
        bit     f3_ok;
        longint w;
        longint b;
        longint h;
        is_load  = (op == OPCODE_L_TYPE);
        is_store = (op == OPCODE_S_TYPE);
        size     = 1 << (int'(f3) % 4);
        off      = int'(a % 4);
        f3_ok    = is_load ? (int'(f3) inside {0, 1, 2, 4, 5}) : (int'(f3) <= 2);
        legal    = f3_ok && ((off % size) == 0);
        rq.we        = is_store;
        rq.maddr     = a - 32'(off);
        rq.strb      = 4'b0000;
        rq.wdata     = 32'd0;
        rq.rdy_delay = 0;
        rq.rsp_delay = 0;
        rq.rdata     = rd;
        if (is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) rq.strb[i] = 1'b1;
                rq.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
            end
        end
        w   = longint'(rd);
        b   = (w >> (8 * off)) % 256;
        h   = (w >> (8 * off)) % 65536;
        val = 32'd0;
        if (is_load && legal) begin
            case (int'(f3))
                0: val = (b >= 128) ? 32'(b - 256) : 32'(b);
                1: val = (h >= 32768) ? 32'(h - 65536) : 32'(h);
                2: val = rd;
                4: val = 32'(b);
                5: val = 32'(h);
                default: val = 32'd0;
            endcase
        end
    endtask

    task automatic randomizeIdleInputs();
        opcode     = 7'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd,
                                 input int dly_rdy, input int dly_rsp, input bit poke_busy);
        bit          legal;
        bit          is_ls;
        req_t        rq;
        rsp_t        rs;
        logic [31:0] val;
        int          target;
        is_ls = (op == OPCODE_L_TYPE) || (op == OPCODE_S_TYPE);
        model(op, f3, a, sd, rd, legal, rq, val);
        rq.rdy_delay = dly_rdy;
        rq.rsp_delay = dly_rsp;
        @(negedge clk);
        start      = 1'b1;
        opcode     = op;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        if (is_ls) begin
            if (legal) req_q.push_back(rq);
            rs.fault = !legal;
            rs.value = val;
            rs.due   = cyc + 1 + (legal ? 2 + dly_rdy + dly_rsp : 0);
            rsp_q.push_back(rs);
        end
        target = done_count + (is_ls ? 1 : 0);
        #1 checkOutput("busy_on_start", 32'(busy), 32'(is_ls));
        @(negedge clk);
        if (poke_busy && is_ls) begin
            start      = 1'b1;
            opcode     = $urandom_range(1) ? OPCODE_L_TYPE : OPCODE_S_TYPE;
            funct3     = 3'($urandom_range(2));
            addr       = $urandom & ~32'h3;
            store_data = $urandom;
            #1 checkOutput("busy_ignores_start", 32'(busy), 32'(legal));
            @(negedge clk);
        end
        start = 1'b0;
        randomizeIdleInputs();
        for (int i = 0; i < 60 && done_count < target; i++) @(negedge clk);
        checkOutput("completion", 32'(done_count), 32'(target));
        if (!is_ls) repeat (2) @(negedge clk);
    endtask

    // Memory responder: checks request fields every cycle they are presented
    initial begin
        req_t rq;
        bit   have;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        forever begin
            @(negedge clk);
            if (auto_mem && !rst && mem_req_valid) begin
                mem_rsp_valid = 1'b0;
                have = (req_q.size() != 0);
                if (!have) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got request at 0x%08h, expected none", mem_addr);
                    rq.rdy_delay = 0;
                    rq.rsp_delay = 0;
                    rq.rdata     = 32'd0;
                end else begin
                    rq = req_q.pop_front();
                end
                for (int k = 0; k <= rq.rdy_delay; k++) begin
                    if (have) begin
                        checkOutput("req_valid", 32'(mem_req_valid), 32'd1);
                        checkOutput("req_we", 32'(mem_we), 32'(rq.we));
                        checkOutput("req_addr", mem_addr, rq.maddr);
                        checkOutput("req_wstrb", 32'(mem_wstrb), 32'(rq.strb));
                        if (rq.we) checkOutput("req_wdata", mem_wdata, rq.wdata);
                        checkOutput("busy_req", 32'(busy), 32'd1);
                    end
                    mem_req_ready = (k == rq.rdy_delay);
                    @(negedge clk);
                end
                mem_req_ready = 1'b0;
                checkOutput("req_dropped", 32'(mem_req_valid), 32'd0);
                for (int k = 0; k < rq.rsp_delay; k++) begin
                    checkOutput("busy_wait", 32'(busy), 32'd1);
                    mem_rdata = $urandom;
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b1;
                mem_rdata     = rq.rdata;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                mem_rdata     = $urandom;
            end else if (auto_mem) begin
                mem_rsp_valid = ($urandom_range(3) == 0);
                mem_rdata     = $urandom;
            end
        end
    end

    // Completion monitor
    initial begin
        rsp_t rs;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_dmem = 32'd0;
            end else begin
                if (done) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done with dmem_out 0x%08h, expected none", dmem_out);
                    end else begin
                        rs = rsp_q.pop_front();
                        checkOutput("fault", 32'(fault), 32'(rs.fault));
                        checkOutput("dmem_out", dmem_out, rs.value);
                        checkOutput("done_cycle", 32'(cyc), 32'(rs.due));
                        model_dmem = rs.value;
                    end
                    done_count++;
                end else begin
                    checkOutput("fault_without_done", 32'(fault), 32'd0);
                end
                checkOutput("dmem_hold", dmem_out, model_dmem);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        randomizeIdleInputs();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_dmem", dmem_out, 32'd0);
        checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(OPCODE_L_TYPE, F3_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        applyStimulus(OPCODE_L_TYPE, F3_LB,  32'h0000_0203, 32'h0, 32'h8012_3456, 0, 0, 1'b0);
        applyStimulus(OPCODE_L_TYPE, F3_LBU, 32'h0000_0203, 32'h0, 32'h8012_3456, 1, 2, 1'b0);
        applyStimulus(OPCODE_S_TYPE, F3_SH,  32'h0000_0102, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);
        applyStimulus(OPCODE_L_TYPE, F3_LW,  32'h0000_0101, 32'h0, 32'h1111_1111, 0, 0, 1'b1);
        applyStimulus(OPCODE_S_TYPE, F3_SW,  32'h0000_0400, 32'hA5A5_5A5A, 32'h0, 3, 0, 1'b1);
        applyStimulus(7'b0110011,    F3_LW,  32'h0000_0500, 32'h0, 32'h0, 0, 0, 1'b0);
        applyStimulus(OPCODE_S_TYPE, 3'd3,   32'h0000_0600, 32'h0, 32'h0, 0, 0, 1'b0);
        applyStimulus(OPCODE_L_TYPE, 3'd6,   32'h0000_0600, 32'h0, 32'h0, 0, 0, 1'b0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            int         pick;
            pick = int'($urandom_range(9));
            op   = (pick < 5) ? OPCODE_L_TYPE : (pick < 9) ? OPCODE_S_TYPE : 7'b0010011;
            applyStimulus(op, 3'($urandom_range(7)), $urandom, $urandom, $urandom,
                          int'($urandom_range(3)), int'($urandom_range(3)), $urandom_range(3) == 0);
        end

        applyStimulus(OPCODE_L_TYPE, F3_LHU, 32'h0000_0002, 32'h0, 32'h1234_ABCD, 0, 1, 1'b0);

        $display("[TB] reset during response wait");
        @(negedge clk);
        auto_mem      = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        start         = 1'b1;
        opcode        = OPCODE_L_TYPE;
        funct3        = F3_LW;
        addr          = 32'h0000_0300;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rst_case_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("rst_case_wait_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_fault", 32'(fault), 32'd0);
        checkOutput("mid_rst_dmem", dmem_out, 32'd0);
        checkOutput("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("mid_rst_we", 32'(mem_we), 32'd0);
        checkOutput("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'd0);
        checkOutput("mid_rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_done", 32'(done), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
            checkOutput("post_rst_req_valid", 32'(mem_req_valid), 32'd0);
        end
        auto_mem = 1'b1;

        applyStimulus(OPCODE_L_TYPE, F3_LH, 32'h0000_0702, 32'h0, 32'h8001_0000, 2, 1, 1'b0);
        checkOutput("queues_drained", 32'(req_q.size() + rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
